imem_loader: RTL

//  Writer side of the fetch-stage instruction ROM: fills the byte-addressed ROM array from a byte stream.
//  It replaces the testbench-only file preload with a framed load protocol: SYNC, LEN, payload, CSUM.
//  It holds the PC register and pipeline in clear (cpu_hold) until a frame has been written and verified.
//  It sits between the off-chip byte source and the ROM write port, next to Register_PC/ROM/Adder.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_ctrl.sv | 108 ++++++++++
 rtl/imem_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-ROM loader: FSM encodings, frame marker and
// the running checksum helper.
package imem_loader_pkg;

  localparam int          LDR_ADDR_W = 8;
  localparam logic [7:0]  LDR_SYNC   = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } ldr_state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    csum_add = acc + b;
  endfunction

endpackage

// File: rtl/imem_loader_ctrl.sv
// Frame FSM for the ROM loader: tracks SYNC/LEN/payload/CSUM, compares the payload
// count against the latched length and emits one-cycle event strobes to the datapath.
module imem_loader_ctrl
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = LDR_SYNC
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       i_restart,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  input  logic [8:0] i_count,
  input  logic [7:0] i_sum,
  output logic       o_rx_ready,
  output logic       o_len_evt,
  output logic       o_data_evt,
  output logic       o_good_evt,
  output logic       o_bad_evt,
  output logic       o_reload_evt
);

  ldr_state_t r_state;
  ldr_state_t w_state_nxt;
  logic [8:0] r_len;
  logic       r_rx_ready;
  logic       w_fire;
  logic       w_is_sync;

  assign o_rx_ready = r_rx_ready;
  assign w_fire     = i_rx_valid && r_rx_ready && !i_restart;
  assign w_is_sync  = (i_rx_data == SYNC_BYTE);

  // State, length and ready registers; ready is precomputed from the next state.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state    <= S_IDLE;
      r_len      <= 9'd0;
      r_rx_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_ready <= (w_state_nxt != S_ERR);
      if (o_len_evt) begin
        r_len <= {(i_rx_data == 8'd0), i_rx_data};
      end
    end
  end

  // Next-state and event decode; a restart overrides any byte on the same edge.
  always_comb begin
    w_state_nxt  = r_state;
    o_len_evt    = 1'b0;
    o_data_evt   = 1'b0;
    o_good_evt   = 1'b0;
    o_bad_evt    = 1'b0;
    o_reload_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fire && w_is_sync) w_state_nxt = S_LEN;
        else                     w_state_nxt = S_IDLE;
      end
      S_LEN: begin
        if (w_fire) begin
          o_len_evt   = 1'b1;
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_LEN;
        end
      end
      S_DATA: begin
        if (w_fire) begin
          o_data_evt = 1'b1;
          if ((i_count + 9'd1) == r_len) w_state_nxt = S_CSUM;
          else                           w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_CSUM: begin
        if (w_fire && (i_rx_data == i_sum)) begin
          o_good_evt  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_fire) begin
          o_bad_evt   = 1'b1;
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_CSUM;
        end
      end
      S_DONE: begin
        if (w_fire && w_is_sync) begin
          o_reload_evt = 1'b1;
          w_state_nxt  = S_LEN;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_restart) begin
      w_state_nxt = S_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Writer side of the fetch-stage instruction ROM: loads a framed byte stream into the
// ROM write port and holds the CPU cleared until a checksummed image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = LDR_ADDR_W,
  parameter logic [7:0]        SYNC_BYTE = LDR_SYNC,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              restart,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [8:0]        count
);

  logic              w_len_evt;
  logic              w_data_evt;
  logic              w_good_evt;
  logic              w_bad_evt;
  logic              w_reload_evt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_din;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;
  logic [8:0]        r_count;
  logic [7:0]        r_sum;

  imem_loader_ctrl #(.SYNC_BYTE(SYNC_BYTE)) u_ctrl (
    .Clk          (Clk),
    .Clr          (Clr),
    .i_restart    (restart),
    .i_rx_valid   (rx_valid),
    .i_rx_data    (rx_data),
    .i_count      (r_count),
    .i_sum        (r_sum),
    .o_rx_ready   (rx_ready),
    .o_len_evt    (w_len_evt),
    .o_data_evt   (w_data_evt),
    .o_good_evt   (w_good_evt),
    .o_bad_evt    (w_bad_evt),
    .o_reload_evt (w_reload_evt)
  );

  // Datapath: ROM write register, payload counter, checksum and sticky status.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= BASE_ADDR;
      r_mem_din  <= 8'd0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= 9'd0;
      r_sum      <= 8'd0;
    end else if (restart) begin
      r_mem_we   <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= 9'd0;
    end else begin
      r_mem_we <= w_data_evt;
      if (w_len_evt) begin
        r_sum      <= 8'd0;
        r_count    <= 9'd0;
        r_mem_addr <= BASE_ADDR;
      end
      if (w_data_evt) begin
        r_mem_din  <= rx_data;
        r_mem_addr <= BASE_ADDR + ADDR_W'(r_count);
        r_count    <= r_count + 9'd1;
        r_sum      <= csum_add(r_sum, rx_data);
      end
      if (w_good_evt) begin
        r_done     <= 1'b1;
        r_cpu_hold <= 1'b0;
      end
      if (w_bad_evt) begin
        r_err      <= 1'b1;
        r_cpu_hold <= 1'b1;
      end
      if (w_reload_evt) begin
        r_done     <= 1'b0;
        r_cpu_hold <= 1'b1;
      end
    end
  end

  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
  assign err      = r_err;
  assign count    = r_count;

endmodule
